// File: rtl/regfile_pkg.sv
// Shared types and widths for the register-file writeback path.
// Holds data/address widths and the requester id used for arbitration.
package regfile_pkg;

   localparam int BUS_SIZE   = 32;
   localparam int REG_ADDR_W = 5;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } req_id_t;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arb2.sv
// Two-way round-robin arbiter for the writeback port.
// In: req_alu, req_mem, prio. Out: one-hot gnt ([0]=ALU, [1]=MEM), prio_nxt.
module rr_arb2
   import regfile_pkg::*;
(
   input  logic       req_alu,
   input  logic       req_mem,
   input  req_id_t    prio,
   output logic [1:0] gnt,
   output req_id_t    prio_nxt
);

   always_comb begin
      gnt      = 2'b00;
      prio_nxt = prio;
      unique case (1'b1)
         (req_alu && req_mem): begin
            gnt      = (prio == REQ_ALU) ? 2'b01 : 2'b10;
            prio_nxt = (prio == REQ_ALU) ? REQ_MEM : REQ_ALU;
         end
         (req_alu && !req_mem): gnt = 2'b01;
         (!req_alu && req_mem): gnt = 2'b10;
         default: ;
      endcase
   end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Shares the register-file write port between ALU and load writeback.
// Ports: alu_*/mem_* handshakes, RegWrite/rd/toReg port, rs1/rs2 -> fwd*.
module regfile_wb_arbiter
   import regfile_pkg::*;
#(
   parameter int BUS_SIZE = regfile_pkg::BUS_SIZE
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  alu_valid,
   input  logic [REG_ADDR_W-1:0] alu_rd,
   input  logic [BUS_SIZE-1:0]   alu_data,
   output logic                  alu_ready,
   input  logic                  mem_valid,
   input  logic [REG_ADDR_W-1:0] mem_rd,
   input  logic [BUS_SIZE-1:0]   mem_data,
   output logic                  mem_ready,
   output logic                  RegWrite,
   output logic [REG_ADDR_W-1:0] rd,
   output logic [BUS_SIZE-1:0]   toReg,
   input  logic [REG_ADDR_W-1:0] rs1,
   input  logic [REG_ADDR_W-1:0] rs2,
   output logic                  fwd1_hit,
   output logic                  fwd2_hit,
   output logic [BUS_SIZE-1:0]   fwd1_data,
   output logic [BUS_SIZE-1:0]   fwd2_data
);

   req_id_t    prio;
   req_id_t    prio_nxt;
   logic [1:0] gnt;

   rr_arb2 u_arb (
      .req_alu  (alu_valid),
      .req_mem  (mem_valid),
      .prio     (prio),
      .gnt      (gnt),
      .prio_nxt (prio_nxt)
   );

   // Nothing is accepted while reset holds the stage.
   assign alu_ready = gnt[0] && !reset;
   assign mem_ready = gnt[1] && !reset;

   always_ff @(posedge clk) begin
      if (reset) begin
         prio     <= REQ_ALU;
         RegWrite <= 1'b0;
         rd       <= '0;
         toReg    <= '0;
      end else begin
         prio <= prio_nxt;
         if (alu_ready) begin
            RegWrite <= (alu_rd != '0);
            rd       <= alu_rd;
            toReg    <= alu_data;
         end else if (mem_ready) begin
            RegWrite <= (mem_rd != '0);
            rd       <= mem_rd;
            toReg    <= mem_data;
         end else begin
            RegWrite <= 1'b0;
         end
      end
   end

   assign fwd1_hit  = RegWrite && (rs1 == rd) && (rs1 != '0);
   assign fwd2_hit  = RegWrite && (rs2 == rd) && (rs2 != '0);
   assign fwd1_data = toReg;
   assign fwd2_data = toReg;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Bench for regfile_wb_arbiter: vector table with expected grants,
// plus a queue of expected staged writes checked one cycle later.
module tb_regfile_wb_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        alu_valid, mem_valid;
   logic [4:0]  alu_rd, mem_rd, rs1, rs2;
   logic [31:0] alu_data, mem_data;
   logic        alu_ready, mem_ready;
   logic        RegWrite;
   logic [4:0]  rd;
   logic [31:0] toReg;
   logic        fwd1_hit, fwd2_hit;
   logic [31:0] fwd1_data, fwd2_data;

   always #5 clk = ~clk;

   regfile_wb_arbiter #(.BUS_SIZE(32)) dut (
      .clk       (clk),
      .reset     (reset),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .mem_valid (mem_valid),
      .mem_rd    (mem_rd),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .RegWrite  (RegWrite),
      .rd        (rd),
      .toReg     (toReg),
      .rs1       (rs1),
      .rs2       (rs2),
      .fwd1_hit  (fwd1_hit),
      .fwd2_hit  (fwd2_hit),
      .fwd1_data (fwd1_data),
      .fwd2_data (fwd2_data)
   );

   typedef struct {
      logic        av;
      logic [4:0]  ar;
      logic [31:0] ad;
      logic        mv;
      logic [4:0]  mr;
      logic [31:0] md;
      logic [4:0]  s1;
      logic [4:0]  s2;
      logic        ea;
      logic        em;
   } vec_t;

   typedef struct {
      logic        we;
      logic [4:0]  rd;
      logic [31:0] data;
   } wr_t;

   wr_t  sb[$];
   vec_t tbl[$];
   int   checks = 0;
   int   failures = 0;
   logic [4:0]  hold_rd;
   logic [31:0] hold_data;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t v(input logic av, input logic [4:0] ar,
         input logic [31:0] ad, input logic mv, input logic [4:0] mr,
         input logic [31:0] md, input logic [4:0] s1, input logic [4:0] s2,
         input logic ea, input logic em);
      vec_t r;
      r = '{av, ar, ad, mv, mr, md, s1, s2, ea, em};
      return r;
   endfunction

   // Called at a negedge; returns at the next negedge after checking
   // the write staged by this cycle's grant.
   task automatic cyc(input vec_t r, input logic rst);
      wr_t e, g;
      reset     = rst;
      alu_valid = r.av;
      alu_rd    = r.ar;
      alu_data  = r.ad;
      mem_valid = r.mv;
      mem_rd    = r.mr;
      mem_data  = r.md;
      rs1       = r.s1;
      rs2       = r.s2;
      #1;
      chk("alu_ready", 32'(alu_ready), 32'(r.ea));
      chk("mem_ready", 32'(mem_ready), 32'(r.em));
      if (rst) begin
         hold_rd = '0;
         hold_data = '0;
         e = '{1'b0, 5'd0, 32'd0};
      end else if (r.ea) begin
         hold_rd = r.ar;
         hold_data = r.ad;
         e = '{(r.ar != 0), r.ar, r.ad};
      end else if (r.em) begin
         hold_rd = r.mr;
         hold_data = r.md;
         e = '{(r.mr != 0), r.mr, r.md};
      end else begin
         e = '{1'b0, hold_rd, hold_data};
      end
      sb.push_back(e);
      @(negedge clk);
      if (sb.size() == 0) begin
         chk("sb_empty", 32'd1, 32'd0);
      end else begin
         g = sb.pop_front();
         chk("RegWrite", 32'(RegWrite), 32'(g.we));
         chk("rd", 32'(rd), 32'(g.rd));
         chk("toReg", toReg, g.data);
         chk("fwd1_hit", 32'(fwd1_hit),
             32'(g.we && rs1 == g.rd && rs1 != 0));
         chk("fwd2_hit", 32'(fwd2_hit),
             32'(g.we && rs2 == g.rd && rs2 != 0));
         chk("fwd1_data", fwd1_data, g.data);
         chk("fwd2_data", fwd2_data, g.data);
      end
   endtask

   vec_t idle;

   initial begin
      hold_rd = '0;
      hold_data = '0;
      idle = v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(negedge clk);
      cyc(idle, 1'b1);
      cyc(v(1, 3, 32'h1, 1, 4, 32'h2, 0, 0, 0, 0), 1'b1);

      // single ALU write
      tbl.push_back(v(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 0, 1, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 5, 0, 0, 0));
      // contention, losers hold
      tbl.push_back(v(1, 1, 32'hA1, 1, 11, 32'hB11, 0, 0, 1, 0));
      tbl.push_back(v(1, 2, 32'hA2, 1, 11, 32'hB11, 0, 0, 0, 1));
      tbl.push_back(v(1, 2, 32'hA2, 1, 12, 32'hB12, 0, 0, 1, 0));
      tbl.push_back(v(1, 3, 32'hA3, 1, 12, 32'hB12, 0, 0, 0, 1));
      tbl.push_back(idle);
      // rd=0 accepted and discarded
      tbl.push_back(v(0, 0, 0, 1, 0, 32'h1234, 0, 0, 0, 1));
      tbl.push_back(idle);
      // forwarding on both ports
      tbl.push_back(v(1, 7, 32'h55, 0, 0, 0, 7, 7, 1, 0));
      tbl.push_back(v(0, 0, 0, 0, 0, 0, 7, 7, 0, 0));
      tbl.push_back(v(1, 8, 32'h66, 0, 0, 0, 8, 9, 1, 0));
      // uncontended MEM grants leave prio at ALU
      tbl.push_back(v(0, 0, 0, 1, 20, 32'hC0, 0, 0, 0, 1));
      tbl.push_back(v(0, 0, 0, 1, 21, 32'hC1, 0, 0, 0, 1));
      tbl.push_back(v(0, 0, 0, 1, 22, 32'hC2, 0, 0, 0, 1));
      tbl.push_back(v(1, 9, 32'hA9, 1, 23, 32'hC3, 9, 23, 1, 0));

      foreach (tbl[i]) cyc(tbl[i], 1'b0);

      // prio now MEM; grant then reset mid-stream
      cyc(v(1, 10, 32'hAA, 0, 0, 0, 10, 0, 1, 0), 1'b0);
      reset = 1'b1;
      #1;
      chk("staged_before_rst", 32'(RegWrite), 32'd1);
      cyc(v(1, 13, 32'hAD, 1, 24, 32'hC4, 13, 24, 0, 0), 1'b1);
      // after release prio is ALU again
      cyc(v(1, 13, 32'hAD, 1, 24, 32'hC4, 13, 24, 1, 0), 1'b0);
      cyc(v(1, 14, 32'hAE, 1, 24, 32'hC4, 0, 24, 0, 1), 1'b0);
      cyc(idle, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
